twobit_comparator: RTL and testbench
====================================

Name: twobit_comparator

Overview:
- Registered magnitude comparator for two small unsigned operands; default width is 2 bits.
- Used inside node to compare the local value against each neighbour value in turn.
- Produces a selectable boolean result `y` plus the three raw relation flags `gt`/`eq`/`lt`.
- One clock domain; all outputs are registered with 1-cycle latency.

Parameters:
- WIDTH, 2, operand width in bits (legal range 1..16).

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, reset; synchronous, active-low (0 = reset, sampled on the clk rising edge).
- a, input, WIDTH, left operand (in node this is the local value).
- b, input, WIDTH, right operand (in node this is the neighbour value).
- op, input, 3, relation select applied to `y`.
- in_vld, input, 1, the operands/op present this cycle are to be compared.
- y, output, 1, registered result of the relation (a op b).
- gt, output, 1, registered flag: a > b.
- eq, output, 1, registered flag: a == b.
- lt, output, 1, registered flag: a < b.
- out_vld, output, 1, registered: y/gt/eq/lt were updated from an accepted input.

Behaviour:
- Reset:
  - When rst==0 at a clk rising edge: y=0, gt=0, eq=0, lt=0, out_vld=0.
  - Reset overrides in_vld on the same edge.
  - A compare in flight is discarded.
- Comparison:
  - Operands are unsigned by default; the full WIDTH is compared, with no truncation or extension.
- op encoding:
  - 000 EQ
  - 001 NE
  - 010 GT (the default usage in node)
  - 011 GE
  - 100 LT
  - 101 LE
  - 110 constant 0
  - 111 constant 1
- Accept (rst==1, in_vld==1 at edge N):
  - At edge N, y/gt/eq/lt load the combinational results for a, b, op.
  - out_vld=1 after edge N. Latency is exactly 1 cycle.
- Hold (in_vld==0):
  - y/gt/eq/lt hold their previous values.
  - out_vld=0 for that cycle, i.e. out_vld is a single-cycle pulse per accepted input.
- Throughput: one compare per cycle. Back-to-back in_vld gives continuous out_vld with per-cycle results.
- Flag invariant: after any accept, exactly one of gt/eq/lt is 1.
- Boundaries:
  - a==b==0: eq=1.
  - a==b==all-ones: eq=1.
  - a=all-ones, b=0: gt=1.
  - a=0, b=all-ones: lt=1.
- Mid-operation reset: rst==0 with in_vld==1 gives reset values, not a compare.
- No X propagation from op. Codes 110/111 are defined constants.

Optional Feature:
- Macro: TWOBIT_COMPARATOR_SIGNED_EN.
- When defined:
  - a and b are compared as WIDTH-bit two's complement values.
  - For WIDTH=2, the order is 10 < 11 < 00 < 01.
  - gt/eq/lt and all op codes use the signed order.
- When undefined: unsigned comparison as above.
- Reset values, latency and the valid protocol are identical in both builds.

Decomposition:
- Shared package twobit_cmp_pkg holds:
  - typedef cmp_op_t (3-bit enum) with constants OP_EQ, OP_NE, OP_GT, OP_GE, OP_LT, OP_LE, OP_ZERO, OP_ONE.
  - Localparam CMP_WIDTH_DEFAULT = 2.
- One natural sub-module, twobit_cmp_core:
  - Purely combinational.
  - Produces gt/eq/lt and the op-selected result.
  - The top level adds the registers and the valid logic.

Test Plan:
- Reset: rst=0 for 2 cycles with in_vld=1, a=3, b=0 -> y=0, gt=eq=lt=0, out_vld=0. Release rst -> outputs stay 0 until the first accept.
- GT sweep, unsigned: op=010, all 16 (a,b) pairs back-to-back -> one cycle later y=1 exactly for pairs such as (3,2), (1,0) and (2,1) (every a>b); out_vld=1 each cycle; exactly one of gt/eq/lt set.
- Op decode: a=2, b=2, op stepped 000..111 -> y sequence 1,0,0,1,0,1,0,1.
- Hold/pulse: accept a=1, b=3 (op=100, y=1, lt=1), then in_vld=0 for 3 cycles with a=3, b=0 -> y=1, lt=1 held; out_vld is 1 for one cycle then 0.
- Mid-stream reset: in_vld=1 continuous, assert rst=0 for one cycle -> that cycle's outputs are all 0 with out_vld=0; next accept resumes with correct results.
- Signed build (TWOBIT_COMPARATOR_SIGNED_EN): a=2'b11, b=2'b01, op=010 -> y=0, lt=1. a=2'b00, b=2'b10 -> gt=1.

Source files
------------

// File: rtl/twobit_comparator_pkg.sv
`default_nettype none
// ============================================================================
// Module   : twobit_cmp_pkg
// Brief    : Shared relation-select encoding and default operand width.
// Revision : 1.0 - initial release
// ============================================================================
package twobit_cmp_pkg;

  localparam int CMP_WIDTH_DEFAULT = 2;

  typedef enum logic [2:0] {
    OP_EQ   = 3'b000,
    OP_NE   = 3'b001,
    OP_GT   = 3'b010,
    OP_GE   = 3'b011,
    OP_LT   = 3'b100,
    OP_LE   = 3'b101,
    OP_ZERO = 3'b110,
    OP_ONE  = 3'b111
  } cmp_op_t;

endpackage
`default_nettype wire

// File: rtl/twobit_comparator_if.sv
`default_nettype none
// ============================================================================
// Module   : twobit_comparator_if
// Brief    : Operand/result bundle between a requester and the comparator.
// Revision : 1.0 - initial release
// ============================================================================
interface twobit_comparator_if #(
  parameter int WIDTH = twobit_cmp_pkg::CMP_WIDTH_DEFAULT
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       op;
  logic             in_vld;
  logic             y;
  logic             gt;
  logic             eq;
  logic             lt;
  logic             out_vld;

  modport master (output a, b, op, in_vld, input y, gt, eq, lt, out_vld);
  modport slave  (input a, b, op, in_vld, output y, gt, eq, lt, out_vld);
endinterface
`default_nettype wire

// File: rtl/twobit_comparator_core.sv
`default_nettype none
// ============================================================================
// Module   : twobit_cmp_core
// Brief    : Combinational relation flags and op-selected result.
//            TWOBIT_COMPARATOR_SIGNED_EN selects two's-complement ordering.
// Revision : 1.0 - initial release
// ============================================================================
module twobit_cmp_core
  import twobit_cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic [2:0]       op,
  output logic                  y,
  output logic                  gt,
  output logic                  eq,
  output logic                  lt
);

  logic w_gt;
  logic w_lt;

`ifdef TWOBIT_COMPARATOR_SIGNED_EN
  assign w_gt = $signed(a) > $signed(b);
  assign w_lt = $signed(a) < $signed(b);
`else
  assign w_gt = a > b;
  assign w_lt = a < b;
`endif

  assign gt = w_gt;
  assign lt = w_lt;
  assign eq = (a == b);

  always_comb begin
    y = 1'b0;
    case (cmp_op_t'(op))
      OP_EQ:   y = eq;
      OP_NE:   y = !eq;
      OP_GT:   y = w_gt;
      OP_GE:   y = !w_lt;
      OP_LT:   y = w_lt;
      OP_LE:   y = !w_gt;
      OP_ZERO: y = 1'b0;
      OP_ONE:  y = 1'b1;
      default: y = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/twobit_comparator.sv
`default_nettype none
// ============================================================================
// Module   : twobit_comparator
// Brief    : Registered magnitude comparator, 1-cycle latency, pulsed valid.
//            TWOBIT_COMPARATOR_SIGNED_EN selects two's-complement ordering.
// Revision : 1.0 - initial release
// ============================================================================
module twobit_comparator
  import twobit_cmp_pkg::*;
#(
  parameter int WIDTH = CMP_WIDTH_DEFAULT
) (
  input  wire logic           clk,
  input  wire logic           rst,
  twobit_comparator_if.slave  bus
);

  logic w_y;
  logic w_gt;
  logic w_eq;
  logic w_lt;

  logic r_y;
  logic r_gt;
  logic r_eq;
  logic r_lt;
  logic r_out_vld;

  twobit_cmp_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a  (bus.a),
    .b  (bus.b),
    .op (bus.op),
    .y  (w_y),
    .gt (w_gt),
    .eq (w_eq),
    .lt (w_lt)
  );

  // Results hold between accepts; only the valid strobe drops back to 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_y       <= 1'b0;
      r_gt      <= 1'b0;
      r_eq      <= 1'b0;
      r_lt      <= 1'b0;
      r_out_vld <= 1'b0;
    end else begin
      r_out_vld <= bus.in_vld;
      if (bus.in_vld) begin
        r_y  <= w_y;
        r_gt <= w_gt;
        r_eq <= w_eq;
        r_lt <= w_lt;
      end
    end
  end

  assign bus.y       = r_y;
  assign bus.gt      = r_gt;
  assign bus.eq      = r_eq;
  assign bus.lt      = r_lt;
  assign bus.out_vld = r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_twobit_comparator.sv
`default_nettype none
// ============================================================================
// Module   : tb_twobit_comparator
// Brief    : Scoreboard bench: stimulus pushes expected per-cycle outputs,
//            monitor pops and compares. Honours TWOBIT_COMPARATOR_SIGNED_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tb_twobit_comparator;

  localparam int W = 2;

  typedef struct {
    bit vld;
    bit y;
    bit gt;
    bit eq;
    bit lt;
  } exp_t;

  logic clk;
  logic rst;
  exp_t sb[$];
  int   n_cmp;
  int   n_fail;
  bit   m_y, m_gt, m_eq, m_lt;

  twobit_comparator_if #(.WIDTH(W)) bus ();

  twobit_comparator #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int to_val(input logic [W-1:0] v);
    int r;
    r = int'(v);
`ifdef TWOBIT_COMPARATOR_SIGNED_EN
    if (r >= (1 << (W - 1))) r = r - (1 << W);
`endif
    return r;
  endfunction

  // One clock of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic step(input bit r, input bit v, input int av, input int bv, input int opv);
    exp_t e;
    logic [W-1:0] a_l;
    logic [W-1:0] b_l;
    logic [2:0]   op_l;
    int va, vb;
    bit [7:0] tab;
    a_l  = av[W-1:0];
    b_l  = bv[W-1:0];
    op_l = opv[2:0];
    rst        = r;
    bus.in_vld = v;
    bus.a      = a_l;
    bus.b      = b_l;
    bus.op     = op_l;
    @(posedge clk);
    if (!r) begin
      {m_y, m_gt, m_eq, m_lt} = 4'b0000;
      e.vld = 1'b0;
    end else if (v) begin
      va   = to_val(a_l);
      vb   = to_val(b_l);
      m_gt = va > vb;
      m_eq = va == vb;
      m_lt = va < vb;
      tab  = {1'b1, 1'b0, va <= vb, va < vb, va >= vb, va > vb, va != vb, va == vb};
      m_y  = tab[op_l];
      e.vld = 1'b1;
    end else begin
      e.vld = 1'b0;
    end
    e.y = m_y; e.gt = m_gt; e.eq = m_eq; e.lt = m_lt;
    sb.push_back(e);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    logic [4:0] got;
    logic [4:0] want;
    if (sb.size() > 0) begin
      e    = sb.pop_front();
      got  = {bus.out_vld, bus.y, bus.gt, bus.eq, bus.lt};
      want = {e.vld, e.y, e.gt, e.eq, e.lt};
      n_cmp++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL outputs {vld,y,gt,eq,lt}: got %b want %b at %0t", got, want, $time);
      end
      if (bus.out_vld === 1'b1) begin
        n_cmp++;
        if ($countones({bus.gt, bus.eq, bus.lt}) != 1) begin
          n_fail++;
          $display("FAIL one_hot_flags: got gt/eq/lt=%b%b%b want exactly one set at %0t",
                   bus.gt, bus.eq, bus.lt, $time);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int r;
    n_cmp  = 0;
    n_fail = 0;
    {m_y, m_gt, m_eq, m_lt} = 4'b0000;
    rst = 1'b0; bus.in_vld = 1'b0; bus.a = '0; bus.b = '0; bus.op = 3'd0;
    @(posedge clk); #1;

    // Reset overrides in_vld, then outputs stay 0 until the first accept.
    step(0, 1, 3, 0, 2);
    step(0, 1, 3, 0, 2);
    step(1, 0, 3, 0, 2);
    step(1, 0, 1, 2, 7);

    // GT sweep over every pair, back-to-back.
    for (int a = 0; a < 4; a++)
      for (int b = 0; b < 4; b++)
        step(1, 1, a, b, 2);

    // Op decode with equal operands.
    for (int o = 0; o < 8; o++) step(1, 1, 2, 2, o);

    // Single accept then holds with changing operands.
    step(1, 1, 1, 3, 4);
    for (int i = 0; i < 3; i++) step(1, 0, 3, 0, 2);

    // Boundary pairs.
    step(1, 1, 0, 0, 0);
    step(1, 1, 3, 3, 0);
    step(1, 1, 3, 0, 2);
    step(1, 1, 0, 3, 4);

    // Signed-order vectors (also valid checks in the unsigned build).
    step(1, 1, 3, 1, 2);
    step(1, 1, 0, 2, 2);

    // Mid-stream reset with continuous in_vld.
    step(1, 1, 2, 1, 2);
    step(0, 1, 2, 1, 2);
    step(1, 1, 1, 2, 5);
    step(1, 1, 3, 2, 3);

    // Random traffic including idle cycles and occasional reset.
    for (int i = 0; i < 300; i++) begin
      r = $urandom;
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 3) != 0),
           r & 3, (r >> 2) & 3, (r >> 4) & 7);
    end

    step(1, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
